// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start(0), DATA_W bits LSB first, stop(1), one bit per clock.
// Payload lands DATA_W+1 edges after the start edge; held in Q under a VALID/ACK handshake.
module sipo_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              D,
  input  logic              ACK,
  output logic [DATA_W-1:0] Q,
  output logic              VALID,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
  output logic              BUSY
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;

  logic               last_bit;
  logic               start_det;
  logic               shift_en;
  logic               stop_ok;
  logic               stop_bad;

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!D) state_d = DATA;
      DATA:    if (last_bit) state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded control strobes
  always_comb begin
    start_det = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      IDLE:    start_det = !D;
      DATA:    shift_en  = 1'b1;
      STOP: begin
        stop_ok  = D;
        stop_bad = !D;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = stop_bad;
    busy_d  = (state_d != IDLE);

    if (start_det) begin
      cnt_d = '0;
    end else if (shift_en) begin
      sreg_d[cnt_q] = D;
      cnt_d         = cnt_q + CNT_W'(1);
    end

    // A good stop wins over ACK: the fresh payload keeps VALID high
    if (stop_ok) begin
      q_d     = sreg_q;
      valid_d = 1'b1;
      if (valid_q && !ACK) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ACK) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      sreg_q  <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign Q         = q_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign BUSY      = busy_q;

endmodule
